// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts a WIDTH-bit word over valid/ready and
// shifts it out one registered bit per clk. Optional macro PARITY_EN appends an even-parity bit.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             busy
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             data_n, valid_n;
  logic             word_end;
`ifdef PARITY_EN
  logic             par, par_n;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= 1'b0;
      data_valid <= 1'b0;
`ifdef PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      data       <= data_n;
      data_valid <= valid_n;
`ifdef PARITY_EN
      par        <= par_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    data_n    = data;
    valid_n   = data_valid;
    word_end  = 1'b0;
`ifdef PARITY_EN
    par_n     = par;
`endif

    case (state)
      IDLE: word_end = 1'b1;
      SHIFT: begin
        if (bit_cnt == LAST) begin
`ifdef PARITY_EN
          state_n = PARITY;
          data_n  = par;
          valid_n = 1'b1;
`else
          word_end = 1'b1;
`endif
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
          data_n    = first_bit(shreg);
          shreg_n   = shift_word(shreg);
          valid_n   = 1'b1;
        end
      end
`ifdef PARITY_EN
      PARITY: word_end = 1'b1;
`endif
      default: state_n = IDLE;
    endcase

    // Every point where a word may start shares this path, so IDLE and the
    // final bit cycle behave identically and back-to-back words have no gap.
    if (word_end) begin
      if (load_valid) begin
        state_n   = SHIFT;
        bit_cnt_n = '0;
        data_n    = first_bit(load_data);
        shreg_n   = shift_word(load_data);
        valid_n   = 1'b1;
`ifdef PARITY_EN
        par_n     = ^load_data;
`endif
      end else begin
        state_n   = IDLE;
        bit_cnt_n = '0;
        data_n    = 1'b0;
        valid_n   = 1'b0;
      end
    end

    load_ready = word_end;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances against a
// queue-of-pending-bits model; honours PARITY_EN when defined.
module tb_serial_bit_feeder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] load_data;
  logic         load_valid;
  logic         ready_m, data_m, valid_m, busy_m;
  logic         ready_l, data_l, valid_l, busy_l;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit q_m[$];
  bit q_l[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_m), .data(data_m), .data_valid(valid_m), .busy(busy_m)
  );

  serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .load_data(load_data), .load_valid(load_valid),
    .load_ready(ready_l), .data(data_l), .data_valid(valid_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // Model: a queue per instance holds the bits still to appear; its head is
  // the bit on 'data' this cycle. Ready means at most the last bit is left.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      q_m.push_back(w[W-1-i]);
      q_l.push_back(w[i]);
    end
`ifdef PARITY_EN
    q_m.push_back(^w);
    q_l.push_back(^w);
`endif
  endtask

  task automatic check_outputs(input string name);
    chk({name, "_valid_m"}, valid_m, q_m.size() > 0);
    chk({name, "_data_m"},  data_m,  (q_m.size() > 0) ? q_m[0] : 1'b0);
    chk({name, "_busy_m"},  busy_m,  q_m.size() > 0);
    chk({name, "_ready_m"}, ready_m, q_m.size() <= 1);
    chk({name, "_valid_l"}, valid_l, q_l.size() > 0);
    chk({name, "_data_l"},  data_l,  (q_l.size() > 0) ? q_l[0] : 1'b0);
    chk({name, "_busy_l"},  busy_l,  q_l.size() > 0);
    chk({name, "_ready_l"}, ready_l, q_l.size() <= 1);
  endtask

  task automatic step(input string name, input logic rn, input logic lv, input logic [W-1:0] ld);
    logic rdy;
    rst_n      = rn;
    load_valid = lv;
    load_data  = ld;
    @(posedge clk);
    rdy = (q_m.size() <= 1);
    if (!rn) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (lv && rdy) push_word(ld);
    end
    #1;
    check_outputs(name);
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;

    step("reset", 1'b0, 1'b1, 8'hFF);
    step("reset", 1'b0, 1'b0, 8'h00);

    step("a5", 1'b1, 1'b1, 8'hA5);
    idle("a5", 11);

    step("w01", 1'b1, 1'b1, 8'h01);
    idle("w01", 11);

    // Back-to-back: hold valid off until the final bit cycle, then offer 00.
    step("b2b", 1'b1, 1'b1, 8'hFF);
`ifdef PARITY_EN
    idle("b2b", 8);
`else
    idle("b2b", 7);
`endif
    step("b2b_last", 1'b1, 1'b1, 8'h00);
    idle("b2b", 12);

    step("abort", 1'b1, 1'b1, 8'hC3);
    idle("abort", 2);
    step("abort_rst", 1'b0, 1'b1, 8'h5A);
    idle("abort_after", 12);

    // Valid held high while busy: only the final-bit-cycle offer is taken.
    step("hold", 1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < 12; i++) step("hold", 1'b1, 1'b1, 8'h00);
    idle("hold", 12);

    step("p07", 1'b1, 1'b1, 8'h07);
    idle("p07", 11);
    step("p03", 1'b1, 1'b1, 8'h03);
    idle("p03", 11);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), W'($urandom));
    idle("drain", 12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
